// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO.
// Holds binary/Gray pointers, count and status flags; storage lives elsewhere.
module fifo_ptr_ctrl #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_accept,
    output logic              rd_accept,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] AF_V    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_V    = PW'(AE_LEVEL);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PART,
        S_FULL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wbin_nxt;
    logic [PW-1:0] rbin_nxt;
    logic [PW-1:0] count_nxt;

    assign full    = (state == S_FULL);
    assign empty   = (state == S_EMPTY);
    assign wr_addr = wbin[ADDR_W-1:0];
    assign rd_addr = rbin[ADDR_W-1:0];

    // Nothing is accepted on a reset edge, so the RAM sees no stray strobe.
    assign wr_accept = wr_en & ~full & ~rst;
    assign rd_accept = rd_en & ~empty & ~rst;

    always_comb begin
        wbin_nxt  = wbin + PW'(wr_accept);
        rbin_nxt  = rbin + PW'(rd_accept);
        count_nxt = count + PW'(wr_accept) - PW'(rd_accept);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_EMPTY: begin
                if (wr_accept && !rd_accept)
                    state_nxt = S_PART;
            end
            S_PART: begin
                if (count_nxt == DEPTH_V)
                    state_nxt = S_FULL;
                else if (count_nxt == '0)
                    state_nxt = S_EMPTY;
            end
            S_FULL: begin
                if (rd_accept && !wr_accept)
                    state_nxt = S_PART;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Gray pointers come from the next binary values so they never lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin         <= '0;
            rbin         <= '0;
            wr_ptr_gray  <= '0;
            rd_ptr_gray  <= '0;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wbin         <= wbin_nxt;
            rbin         <= rbin_nxt;
            wr_ptr_gray  <= wbin_nxt ^ (wbin_nxt >> 1);
            rd_ptr_gray  <= rbin_nxt ^ (rbin_nxt >> 1);
            count        <= count_nxt;
            almost_full  <= (count_nxt >= AF_V);
            almost_empty <= (count_nxt <= AE_V);
            overflow     <= wr_en & full;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed testbench for fifo_ptr_ctrl.
// Scenario tasks with hand-computed expectations.
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] wr_addr;
    logic [2:0] rd_addr;
    logic       wr_accept;
    logic       rd_accept;
    logic [3:0] wr_ptr_gray;
    logic [3:0] rd_ptr_gray;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int failures = 0;

    fifo_ptr_ctrl #(
        .DEPTH(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .wr_addr(wr_addr), .rd_addr(rd_addr),
        .wr_accept(wr_accept), .rd_accept(rd_accept),
        .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [22:0] got;
        logic [22:0] exp_v;
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got = {wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray, count,
               full, empty, almost_full, almost_empty, overflow, underflow};
        exp_v = {3'd0, 3'd0, 4'd0, 4'd0, 4'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_underflow;
        rd_en = 1'b1;
        #1;
        checks++;
        if (rd_accept !== 1'b0) begin
            failures++;
            $display("FAIL udf_rd_accept got=%b exp=0", rd_accept);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if ({underflow, rd_addr, count, empty} !== {1'b1, 3'd0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL udf_pulse got=%b/%0d/%0d/%b exp=1/0/0/1",
                     underflow, rd_addr, count, empty);
        end
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL udf_one_cycle got=%b exp=0", underflow);
        end
    endtask

    task automatic test_empty_simul;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if ({count, underflow, empty, wr_addr, rd_addr, wr_ptr_gray} !==
            {4'd1, 1'b1, 1'b0, 3'd1, 3'd0, 4'b0001}) begin
            failures++;
            $display("FAIL empty_simul got=%0d/%b/%b/%0d/%0d/%b exp=1/1/0/1/0/0001",
                     count, underflow, empty, wr_addr, rd_addr, wr_ptr_gray);
        end
    endtask

    task automatic test_fill;
        logic [3:0] gtab [8];
        gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1;
            #1;
            checks++;
            if (wr_accept !== 1'b1 || wr_addr !== 3'(i - 1)) begin
                failures++;
                $display("FAIL fill_accept_%0d got=%b/%0d exp=1/%0d",
                         i, wr_accept, wr_addr, i - 1);
            end
            tick();
            checks++;
            if ({count, wr_ptr_gray, full, empty, almost_full, almost_empty} !==
                {4'(i), gtab[i-1], (i == 8), 1'b0, (i >= 6), (i <= 2)}) begin
                failures++;
                $display("FAIL fill_%0d got=%0d/%b/%b%b%b%b exp=%0d/%b/%b0%b%b",
                         i, count, wr_ptr_gray, full, empty, almost_full,
                         almost_empty, i, gtab[i-1], (i == 8), (i >= 6), (i <= 2));
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow;
        wr_en = 1'b1;
        #1;
        checks++;
        if (wr_accept !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wr_accept got=%b exp=0", wr_accept);
        end
        tick();
        wr_en = 1'b0;
        checks++;
        if ({overflow, count, wr_ptr_gray, wr_addr, full} !==
            {1'b1, 4'd8, 4'b1100, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_pulse got=%b/%0d/%b/%0d/%b exp=1/8/1100/0/1",
                     overflow, count, wr_ptr_gray, wr_addr, full);
        end
        tick();
        checks++;
        if (overflow !== 1'b0 || count !== 4'd8) begin
            failures++;
            $display("FAIL ovf_one_cycle got=%b/%0d exp=0/8", overflow, count);
        end
    endtask

    task automatic test_full_simul;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if ({count, full, overflow, rd_ptr_gray, wr_ptr_gray, rd_addr, almost_full} !==
            {4'd7, 1'b0, 1'b1, 4'b0001, 4'b1100, 3'd1, 1'b1}) begin
            failures++;
            $display("FAIL full_simul got=%0d/%b/%b/%b/%b/%0d/%b exp=7/0/1/0001/1100/1/1",
                     count, full, overflow, rd_ptr_gray, wr_ptr_gray, rd_addr,
                     almost_full);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] wb;
        logic [3:0] rb;
        logic [3:0] wg;
        logic [3:0] rg;
        logic       gfull;
        do_reset();
        wr_en = 1'b1;
        tick();
        tick();
        tick();
        wb = 4'd3;
        rb = 4'd0;
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (wr_accept !== 1'b1 || rd_accept !== 1'b1) begin
                failures++;
                $display("FAIL b2b_accept_%0d got=%b%b exp=11", i, wr_accept, rd_accept);
            end
            tick();
            wb = wb + 4'd1;
            rb = rb + 4'd1;
            wg = wb ^ (wb >> 1);
            rg = rb ^ (rb >> 1);
            gfull = (wr_ptr_gray[3:2] == ~rd_ptr_gray[3:2]) &&
                    (wr_ptr_gray[1:0] == rd_ptr_gray[1:0]);
            checks++;
            if ({count, wr_ptr_gray, rd_ptr_gray, wr_addr, rd_addr, full} !==
                {4'd3, wg, rg, wb[2:0], rb[2:0], 1'b0} || gfull !== full) begin
                failures++;
                $display("FAIL b2b_%0d got=%0d/%b/%b/%0d/%0d/%b/%b exp=3/%b/%b/%0d/%0d/0/0",
                         i, count, wr_ptr_gray, rd_ptr_gray, wr_addr, rd_addr,
                         full, gfull, wg, rg, wb[2:0], rb[2:0]);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (wr_ptr_gray !== 4'b0100 || rd_ptr_gray !== 4'b0110) begin
            failures++;
            $display("FAIL b2b_wrap got=%b/%b exp=0100/0110", wr_ptr_gray, rd_ptr_gray);
        end
    endtask

    task automatic test_fill_gray_full;
        logic gfull;
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        wr_en = 1'b0;
        gfull = (wr_ptr_gray[3:2] == ~rd_ptr_gray[3:2]) &&
                (wr_ptr_gray[1:0] == rd_ptr_gray[1:0]);
        checks++;
        if (full !== 1'b1 || gfull !== 1'b1) begin
            failures++;
            $display("FAIL gray_full got=%b/%b exp=1/1", full, gfull);
        end
    endtask

    task automatic test_reset_mid;
        logic [22:0] got;
        logic [22:0] exp_v;
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("FAIL mid_count got=%0d exp=5", count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wr_accept !== 1'b0) begin
            failures++;
            $display("FAIL mid_wr_accept got=%b exp=0", wr_accept);
        end
        tick();
        rst = 1'b0;
        wr_en = 1'b0;
        got = {wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray, count,
               full, empty, almost_full, almost_empty, overflow, underflow};
        exp_v = {3'd0, 3'd0, 4'd0, 4'd0, 4'd0,
                 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", got, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        test_reset();
        test_underflow();
        test_empty_simul();
        do_reset();
        test_fill();
        test_overflow();
        test_full_simul();
        test_back_to_back();
        test_fill_gray_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Single-clock pointer and flag controller for the 8-entry FIFO. Accepts write/read requests, gates them against full/empty, and drives the binary RAM addresses. It also publishes Gray-coded pointers, which downstream Gray-to-binary conversion and pointer-export logic consume. It holds all FIFO occupancy state; the storage array is a separate block.

## Interface

Parameters:
- DEPTH, 8, number of entries; power of two, at least 4.
- ADDR_W, 3, RAM address width; equals clog2(DEPTH). Pointers are ADDR_W+1 bits.
- AF_LEVEL, 6, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- wr_addr  out  ADDR_W  RAM write address (binary write pointer, low bits).
- rd_addr  out  ADDR_W  RAM read address (binary read pointer, low bits).
- wr_accept  out  1  combinational; wr_en && !full. Drives the RAM write strobe.
- rd_accept  out  1  combinational; rd_en && !empty.
- wr_ptr_gray  out  ADDR_W+1  registered Gray code of the binary write pointer.
- rd_ptr_gray  out  ADDR_W+1  registered Gray code of the binary read pointer.
- count  out  ADDR_W+1  registered occupancy, 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1  registered flags.
- overflow  out  1  registered one-cycle pulse: wr_en while full.
- underflow  out  1  registered one-cycle pulse: rd_en while empty.

## Operation

- Binary pointers wbin and rbin are ADDR_W+1 bits and wrap modulo 2·DEPTH. wr_addr and rd_addr are their low ADDR_W bits.
- Gray encoding: gray = bin ^ (bin >> 1). The Gray outputs are registered from the next-state binary values, so they always match the current wbin and rbin.
- Occupancy FSM states are S_EMPTY, S_PART and S_FULL.
  - S_EMPTY → S_PART on an accepted write.
  - S_PART → S_FULL when the next count equals DEPTH.
  - S_PART → S_EMPTY when the next count equals 0.
  - S_FULL → S_PART on an accepted read.
  - An accepted write and accepted read in the same cycle leave the state unchanged.
  - empty = (state == S_EMPTY) and full = (state == S_FULL), both registered.
- Count update: next count = count + wr_accept − rd_accept.
- Invariant: count == wbin − rbin (mod 2·DEPTH).
- Gray full condition: the top two bits of wr_ptr_gray equal the inverted top two bits of rd_ptr_gray, and the remaining bits are equal. This condition must agree with full every cycle.
- Simultaneous requests:
  - When full, the read is accepted, the write is rejected and overflow pulses; next count = DEPTH−1.
  - When empty, the write is accepted, the read is rejected and underflow pulses; next count = 1.
  - In S_PART, both are accepted, count is unchanged and both pointers advance.
- Rejected requests never move pointers or count.
- almost_full and almost_empty are computed from the next count and registered.
- Reset values:
  - wbin = rbin = 0, so wr_addr = rd_addr = 0 and both Gray pointers are 0.
  - count = 0, state = S_EMPTY, empty = 1, almost_empty = 1.
  - full, almost_full, overflow and underflow are 0.
- Reset mid-operation: on the reset edge, every register returns to its reset value regardless of wr_en or rd_en, and no requests are accepted that cycle. Reset has priority over everything.

## Timing

- Accepted write at edge N:
  - wr_addr at edge N is the address written.
  - wbin, wr_ptr_gray and count update at edge N.
  - Flags reflect the new count immediately after edge N.
- Accepted read at edge N: rd_addr before edge N selects the entry read. The RAM is registered-read, so data is valid one cycle after rd_accept.
- The flags have zero cycles of lag relative to count. empty deasserts in the cycle after the first write.
- overflow and underflow are high for exactly one cycle following each offending edge.
- Back-to-back accepts at one per cycle are sustained indefinitely, with no bubbles.

## Test plan

- Reset, then 8 consecutive writes. Expected:
  - count steps 1..8 and full rises after the 8th edge.
  - almost_full rises after the 6th edge and empty falls after the 1st.
  - wr_ptr_gray sequence is 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100.
- From full, a 9th write → overflow pulses for one cycle; wbin, count and wr_ptr_gray are unchanged.
- From full, wr_en and rd_en together → the write is rejected and overflow pulses; count = 7, full = 0, rd_ptr_gray = 0001.
- 20 cycles of simultaneous wr_en/rd_en at count 3 → count stays at 3 and both pointers wrap past 15 to 0.
  - On every cycle, the Gray outputs must equal bin ^ (bin >> 1).
  - The Gray full condition must agree with full on every cycle.
- From empty after reset, rd_en alone → underflow pulses; rd_addr stays 0.
- From empty, wr_en and rd_en together → count = 1 and underflow pulses.
- At count 5, assert rst with wr_en = 1 → on the next edge, all outputs take their reset values and no write is accepted.
